// File: rtl/sdm_dac_mod2.sv
// 1st/2nd-order single-bit sigma-delta DAC modulator with a one-sample input buffer,
// OSR modulator steps per sample and an optional clock-divided step rate.
module sdm_dac_mod2 #(
   parameter int DW      = 16,
   parameter int EXT     = 4,
   parameter int OSR     = 64,
   parameter int CLK_DIV = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          order2,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   output logic          dout,
   output logic          dout_valid,
   output logic          underrun,
   output logic          sat,
   input  logic          clr_flags
);

   localparam int ACC_W = DW + EXT;
   localparam int SW    = ACC_W + 1;
   localparam int OW    = $clog2(OSR);
   localparam int DVW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int FS_I  = 2 ** (DW - 1);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t                   state;
   logic                     en_r;
   logic                     buf_full;
   logic                     mode_r;
   logic [DW-1:0]            buf_q;
   logic [DW-1:0]            cur;
   logic signed [ACC_W-1:0]  i1, i2;
   logic [OW-1:0]            osr_cnt;
   logic [DVW-1:0]           div_cnt;

   logic                     ce, accept, boundary;
   logic signed [SW-1:0]     i1_x, i2_x, cur_x, fb, s1, s2;
   logic signed [ACC_W-1:0]  i1_n, i2_n;
   logic                     ovf1, ovf2, bit_n;

   function automatic logic signed [ACC_W-1:0] clamp(input logic signed [SW-1:0] s);
      if (s[SW-1] != s[SW-2])
         return s[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      return s[ACC_W-1:0];
   endfunction

   assign s_ready  = en_r & ~buf_full;
   assign accept   = s_valid & s_ready;
   assign ce       = (state != IDLE) && (div_cnt == DVW'(CLK_DIV - 1));
   assign boundary = (osr_cnt == OW'(OSR - 1));

   // Feedback uses the previously emitted bit; second integrator sees the old i1.
   always_comb begin
      i1_x  = {i1[ACC_W-1], i1};
      i2_x  = {i2[ACC_W-1], i2};
      cur_x = {{(SW-DW){cur[DW-1]}}, cur};
      fb    = dout ? SW'(FS_I) : -SW'(FS_I);
      s1    = i1_x + cur_x - fb;
      s2    = i2_x + i1_x - fb;
      ovf1  = s1[SW-1] ^ s1[SW-2];
      ovf2  = mode_r & (s2[SW-1] ^ s2[SW-2]);
      i1_n  = clamp(s1);
      i2_n  = mode_r ? clamp(s2) : '0;
      bit_n = mode_r ? ~i2_n[ACC_W-1] : ~i1_n[ACC_W-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         en_r       <= 1'b0;
         buf_full   <= 1'b0;
         mode_r     <= 1'b0;
         buf_q      <= '0;
         cur        <= '0;
         i1         <= '0;
         i2         <= '0;
         osr_cnt    <= '0;
         div_cnt    <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         underrun   <= 1'b0;
         sat        <= 1'b0;
      end else begin
         en_r       <= en;
         dout_valid <= 1'b0;
         underrun   <= 1'b0;
         if (clr_flags)
            sat <= 1'b0;

         if (!en_r) begin
            state    <= IDLE;
            buf_full <= 1'b0;
            i1       <= '0;
            i2       <= '0;
            osr_cnt  <= '0;
            div_cnt  <= '0;
            dout     <= 1'b0;
         end else begin
            if (accept) begin
               buf_q    <= s_data;
               buf_full <= 1'b1;
            end

            if (state == IDLE || div_cnt == DVW'(CLK_DIV - 1))
               div_cnt <= '0;
            else
               div_cnt <= div_cnt + 1'b1;

            case (state)
               IDLE: state <= PRIME;
               PRIME: begin
                  if (ce && buf_full) begin
                     cur      <= buf_q;
                     mode_r   <= order2;
                     buf_full <= 1'b0;
                     osr_cnt  <= '0;
                     state    <= RUN;
                  end
               end
               RUN: begin
                  if (ce) begin
                     i1         <= i1_n;
                     i2         <= i2_n;
                     dout       <= bit_n;
                     dout_valid <= 1'b1;
                     if (ovf1 || ovf2)
                        sat <= 1'b1;
                     osr_cnt <= boundary ? '0 : osr_cnt + 1'b1;
                     // Frame boundary: take the buffered sample, or hold cur and flag it.
                     if (boundary) begin
                        if (buf_full) begin
                           cur      <= buf_q;
                           mode_r   <= order2;
                           buf_full <= 1'b0;
                        end else begin
                           underrun <= 1'b1;
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sdm_dac_mod2.sv
// Directed bench for sdm_dac_mod2: a default instance (OSR=64, CLK_DIV=1) and a
// small divided-rate instance (OSR=8, CLK_DIV=4).
module tb_sdm_dac_mod2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0, order2 = 1'b0, s_valid = 1'b0, clr_flags = 1'b0;
   logic [15:0] s_data = '0;
   logic        s_ready, dout, dout_valid, underrun, sat;

   logic        en4 = 1'b0, s_valid4 = 1'b0;
   logic [15:0] s_data4 = '0;
   logic        s_ready4, dout4, dout_valid4, underrun4, sat4;

   int checks = 0, errors = 0;
   int steps_tot = 0, ones_tot = 0, urun_tot = 0, acc_tot = 0, acc4_tot = 0;

   always #5 clk = ~clk;

   sdm_dac_mod2 #(.DW(16), .EXT(4), .OSR(64), .CLK_DIV(1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .order2(order2),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .dout(dout), .dout_valid(dout_valid), .underrun(underrun),
      .sat(sat), .clr_flags(clr_flags));

   sdm_dac_mod2 #(.DW(16), .EXT(4), .OSR(8), .CLK_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .order2(1'b0),
      .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
      .dout(dout4), .dout_valid(dout_valid4), .underrun(underrun4),
      .sat(sat4), .clr_flags(1'b0));

   always @(negedge clk) begin
      if (dout_valid) begin
         steps_tot++;
         if (dout) ones_tot++;
      end
      if (underrun) urun_tot++;
   end

   always @(posedge clk) begin
      if (s_valid && s_ready) acc_tot++;
      if (s_valid4 && s_ready4) acc4_tot++;
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   // Waits for n modulator steps on the default instance; reports ones/underruns seen.
   task automatic wait_steps(input string tag, input int n, output int ones, output int uruns);
      int s0 = steps_tot;
      int o0 = ones_tot;
      int u0 = urun_tot;
      int cyc = 0;
      while (steps_tot < s0 + n && cyc < 4 * n + 100) begin
         @(negedge clk); #1;
         cyc++;
      end
      chk(tag, steps_tot - s0, n);
      ones  = ones_tot - o0;
      uruns = urun_tot - u0;
   endtask

   initial begin
      int ones, ur, a0, cyc, dv, rdy, last, gap_bad;

      // Reset state
      #3;
      chk("rst_dout", dout, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_sat", sat, 0);
      cycles(3);
      rst_n = 1'b1;
      cycles(2);

      // 1st order, constant 0: bits 1,1,0 then alternating
      order2 = 1'b0; s_data = 16'd0; s_valid = 1'b1; en = 1'b1;
      wait_steps("st_a", 1, ones, ur); chk("m1_bit1", dout, 1);
      wait_steps("st_b", 1, ones, ur); chk("m1_bit2", dout, 1);
      wait_steps("st_c", 1, ones, ur); chk("m1_bit3", dout, 0);
      wait_steps("st_d", 61, ones, ur);
      wait_steps("st_e", 64, ones, ur);
      chk("m1_zero_ones", ones, 32);
      chk("m1_no_underrun", ur, 0);

      // 2nd order, +/- half scale
      order2 = 1'b1; s_data = 16'd16384;
      wait_steps("st_f", 256, ones, ur);
      wait_steps("st_g", 64, ones, ur); chk_rng("m2_pos_ones_a", ones, 47, 49);
      wait_steps("st_h", 64, ones, ur); chk_rng("m2_pos_ones_b", ones, 47, 49);
      s_data = 16'hC000;
      wait_steps("st_i", 256, ones, ur);
      wait_steps("st_j", 64, ones, ur); chk_rng("m2_neg_ones", ones, 15, 17);
      chk("m2_no_sat", sat, 0);

      // Near full scale drives the 2nd-order loop into clamping
      s_data = 16'd32767;
      wait_steps("st_k", 256, ones, ur);
      chk("sat_set", sat, 1);
      s_data = 16'd0; en = 1'b0;
      cycles(3);
      chk("sat_sticky_idle", sat, 1);
      chk("idle_s_ready", s_ready, 0);
      chk("idle_dout", dout, 0);
      en = 1'b1;
      wait_steps("st_l", 128, ones, ur);
      clr_flags = 1'b1; cycles(1); clr_flags = 1'b0;
      wait_steps("st_m", 192, ones, ur);
      chk("sat_cleared", sat, 0);

      // Single sample then starve: underrun once per frame, density unchanged
      en = 1'b0; s_valid = 1'b0; order2 = 1'b0; s_data = 16'd0;
      cycles(3);
      a0 = acc_tot;
      en = 1'b1; s_valid = 1'b1;
      cyc = 0;
      while (acc_tot == a0 && cyc < 20) begin cycles(1); cyc++; end
      s_valid = 1'b0;
      chk("one_accept", acc_tot - a0, 1);
      wait_steps("st_n", 64, ones, ur);
      wait_steps("st_o", 128, ones, ur);
      chk("ur_count", ur, 2);
      chk("ur_ones", ones, 64);
      chk("ur_s_ready", s_ready, 1);
      chk("ur_accepts", acc_tot - a0, 1);

      // Asynchronous reset while saturating in RUN
      order2 = 1'b1; s_data = 16'd32767; s_valid = 1'b1;
      wait_steps("st_p", 128, ones, ur);
      chk("pre_rst_sat", sat, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_dout", dout, 0);
      chk("mid_rst_dout_valid", dout_valid, 0);
      chk("mid_rst_s_ready", s_ready, 0);
      chk("mid_rst_underrun", underrun, 0);
      chk("mid_rst_sat", sat, 0);
      en = 1'b0; s_valid = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      cycles(2);

      // Divided rate: one step per 4 clks, one accept per 32-clk frame
      en4 = 1'b1; s_valid4 = 1'b1; s_data4 = 16'd0;
      cycles(200);
      a0 = acc4_tot; dv = 0; rdy = 0; last = -1; gap_bad = 0;
      for (int i = 0; i < 32; i++) begin
         cycles(1);
         if (s_ready4) rdy++;
         if (dout_valid4) begin
            if (last >= 0 && i - last != 4) gap_bad++;
            last = i;
            dv++;
         end
      end
      chk("div_valid_cnt", dv, 8);
      chk("div_gap_bad", gap_bad, 0);
      chk("div_ready_cycles", rdy, 1);
      chk("div_accepts", acc4_tot - a0, 1);
      chk("div_underrun", underrun4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
